dbus_initiator: RTL and testbench

Data-bus initiator that issues single read/write transactions to dbus responder peripherals such as GPIO, UART and timers, and collects their acknowledgements. Commands enter through a small valid/ready command queue. Each command drives one `type_dbus2peri_s` request plus a peripheral select. The returned `type_peri2dbus_s` ack and read data are delivered on a valid/ready response port. The block sits between a host-side agent (debug bridge, DMA sequencer) and the peripheral bus fabric.

---
 rtl/dbus_initiator_pkg.sv | 31 +++
 rtl/dbus_initiator_if.sv | 30 +++
 rtl/dbus_initiator_cmd_fifo.sv | 63 ++++++
 rtl/dbus_initiator.sv | 147 ++++++++++++++
 tb/tb_dbus_initiator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_initiator_pkg.sv
// Shared data-bus peripheral definitions: request/ack structs, queued command
// entry and the initiator FSM state encoding.
package dbus_initiator_pkg;

  localparam int DBUS_DW = 32;

  typedef struct packed {
    logic [DBUS_DW-1:0] addr;
    logic [DBUS_DW-1:0] w_data;
    logic               w_en;
    logic               req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic               ack;
    logic [DBUS_DW-1:0] r_data;
  } type_peri2dbus_s;

  typedef struct packed {
    logic [DBUS_DW-1:0] addr;
    logic [DBUS_DW-1:0] wdata;
    logic               we;
  } type_dbus_cmd_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } type_dbus_init_state_e;

endpackage

// File: rtl/dbus_initiator_if.sv
// Command, response and peripheral-bus signals of the dbus initiator.
// master = the initiator itself; slave = host agent plus peripheral fabric.
interface dbus_initiator_if;
  import dbus_initiator_pkg::*;

  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [31:0]     cmd_addr_i;
  logic [31:0]     cmd_wdata_i;
  logic            cmd_we_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_we_o;
  logic            rsp_err_o;
  logic            peri_sel_o;
  type_dbus2peri_s dbus2peri_o;
  type_peri2dbus_s peri2dbus_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_we_i, rsp_ready_i, peri2dbus_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_err_o, peri_sel_o, dbus2peri_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_we_i, rsp_ready_i, peri2dbus_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_err_o, peri_sel_o, dbus2peri_o
  );

endinterface

// File: rtl/dbus_initiator_cmd_fifo.sv
// Synchronous command FIFO for the dbus initiator; CMD_DEPTH must be a power
// of two so the pointers wrap naturally.
module dbus_cmd_fifo
  import dbus_initiator_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic           pop_i,
  input  type_dbus_cmd_s data_i,
  output logic           full_o,
  output logic           empty_o,
  output type_dbus_cmd_s head_o
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  type_dbus_cmd_s   mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(CMD_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head is read asynchronously so the FSM can latch it in the pop cycle.
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dbus_initiator.sv
// Single-outstanding dbus initiator: queued commands become one request each,
// acks are returned in order. Optional request timeout: DBUS_INIT_TIMEOUT_EN.
module dbus_initiator
  import dbus_initiator_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  dbus_initiator_if.master bus,
  output logic             busy_o
);

  type_dbus_init_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_we_q, rsp_we_d;
  logic        rsp_err_q, rsp_err_d;

  logic           fifo_pop, fifo_full, fifo_empty;
  logic           timeout_hit;
  type_dbus_cmd_s fifo_head, fifo_in;

  assign fifo_in = '{addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i, we: bus.cmd_we_i};

  dbus_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.cmd_valid_i),
    .pop_i   (fifo_pop),
    .data_i  (fifo_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifdef DBUS_INIT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (state_q == REQ) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = (state_q == REQ) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout the request waits forever; the parameter is inert.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_head.addr;
          wdata_d  = fifo_head.we ? fifo_head.wdata : 32'd0;
          we_d     = fifo_head.we;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // An ack coinciding with the timeout wins, so it is tested first.
        if (bus.peri2dbus_i.ack) begin
          rsp_rdata_d = we_q ? 32'd0 : bus.peri2dbus_i.r_data;
          rsp_err_d   = 1'b0;
          rsp_we_d    = we_q;
          rsp_valid_d = 1'b1;
          req_d       = 1'b0;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          rsp_we_d    = we_q;
          rsp_valid_d = 1'b1;
          req_d       = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready_o = !fifo_full;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_we_o    = rsp_we_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.peri_sel_o  = req_q;
  assign bus.dbus2peri_o = '{addr: addr_q, w_data: wdata_q, w_en: we_q, req: req_q};
  assign busy_o          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_dbus_initiator.sv
// Directed bench for dbus_initiator with a small gpio-like responder model
// that acks one cycle after it sees req.
module tb_dbus_initiator;
  import dbus_initiator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dbus_initiator_if bus_if();

  dbus_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .busy_o (busy)
  );

  // Responder: register file of four words indexed by addr[3:2].
  logic        resp_en = 1'b0;
  logic        man_ack = 1'b0;
  logic        auto_ack;
  logic [31:0] resp_rdata;
  logic [31:0] gpio_regs [4];

  always @(posedge clk) begin
    if (rst) begin
      auto_ack   <= 1'b0;
      resp_rdata <= 32'd0;
      for (int i = 0; i < 4; i++) gpio_regs[i] <= 32'd0;
    end else begin
      auto_ack <= 1'b0;
      if (resp_en && bus_if.dbus2peri_o.req && !auto_ack) begin
        auto_ack <= 1'b1;
        if (bus_if.dbus2peri_o.w_en) begin
          gpio_regs[bus_if.dbus2peri_o.addr[3:2]] <= bus_if.dbus2peri_o.w_data;
          resp_rdata <= 32'd0;
        end else begin
          resp_rdata <= gpio_regs[bus_if.dbus2peri_o.addr[3:2]];
        end
      end
    end
  end

  assign bus_if.peri2dbus_i = type_peri2dbus_s'{ack: auto_ack | man_ack, r_data: resp_rdata};

  // Count request issues and cycles where req and ack overlap.
  int   req_rises = 0;
  int   ack_req_cycles = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (bus_if.dbus2peri_o.req && !req_prev) req_rises <= req_rises + 1;
    if (bus_if.dbus2peri_o.req && bus_if.peri2dbus_i.ack) ack_req_cycles <= ack_req_cycles + 1;
    req_prev <= bus_if.dbus2peri_o.req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic we);
    int guard = 0;
    bus_if.cmd_addr_i  = a;
    bus_if.cmd_wdata_i = d;
    bus_if.cmd_we_i    = we;
    bus_if.cmd_valid_i = 1'b1;
    while (!bus_if.cmd_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    chk("push_ready", bus_if.cmd_ready_o, 1);
    tick();
    bus_if.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int guard = 0;
    while (!bus_if.rsp_valid_o && guard < 40) begin
      tick();
      guard++;
    end
    chk(tag, bus_if.rsp_valid_o, 1);
  endtask

  // Queue-full table: entry 0 goes in flight, entries 1..4 fill the queue.
  logic [31:0] q_addr [5] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h0};
  logic [31:0] q_wd   [5] = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h0};
  logic        q_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] q_exp  [5] = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h11};

  initial begin
    int base;
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_addr_i  = 32'd0;
    bus_if.cmd_wdata_i = 32'd0;
    bus_if.cmd_we_i    = 1'b0;
    bus_if.rsp_ready_i = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", bus_if.cmd_ready_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus_if.dbus2peri_o.req, 0);
    chk("rst_peri_sel", bus_if.peri_sel_o, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid_o, 0);
    chk("rst_rsp_err", bus_if.rsp_err_o, 0);
    chk("rst_rsp_we", bus_if.rsp_we_o, 0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata_o, 0);
    chk("rst_addr", bus_if.dbus2peri_o.addr, 0);
    chk("rst_wdata", bus_if.dbus2peri_o.w_data, 0);

    // Latency: write 0xA5 to DIR (0x4), handshake at N
    resp_en = 1'b1;
    base = req_rises;
    push(32'h4, 32'hA5, 1'b1);
    chk("lat_n1_req", bus_if.dbus2peri_o.req, 0);
    chk("lat_n1_busy", busy, 1);
    tick();
    chk("lat_n2_req", bus_if.dbus2peri_o.req, 1);
    chk("lat_n2_sel", bus_if.peri_sel_o, 1);
    chk("lat_n2_addr", bus_if.dbus2peri_o.addr, 32'h4);
    chk("lat_n2_wen", bus_if.dbus2peri_o.w_en, 1);
    chk("lat_n2_wdata", bus_if.dbus2peri_o.w_data, 32'hA5);
    tick();
    chk("lat_n3_req", bus_if.dbus2peri_o.req, 1);
    chk("lat_n3_rsp_valid", bus_if.rsp_valid_o, 0);
    tick();
    chk("lat_n4_req", bus_if.dbus2peri_o.req, 0);
    chk("lat_n4_rsp_valid", bus_if.rsp_valid_o, 1);
    chk("wr_rsp_we", bus_if.rsp_we_o, 1);
    chk("wr_rsp_err", bus_if.rsp_err_o, 0);
    chk("wr_rsp_rdata", bus_if.rsp_rdata_o, 0);

    // Backpressure: queue a read-back while the write response is held
    push(32'h4, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), bus_if.rsp_valid_o, 1);
      chk($sformatf("bp%0d_we", i), bus_if.rsp_we_o, 1);
      chk($sformatf("bp%0d_err", i), bus_if.rsp_err_o, 0);
      chk($sformatf("bp%0d_rdata", i), bus_if.rsp_rdata_o, 0);
      chk($sformatf("bp%0d_req", i), bus_if.dbus2peri_o.req, 0);
      if (i < 4) tick();
    end
    chk("bp_req_count", req_rises - base, 1);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    chk("rd_m1_valid", bus_if.rsp_valid_o, 0);
    chk("rd_m1_req", bus_if.dbus2peri_o.req, 0);
    tick();
    chk("rd_m2_req", bus_if.dbus2peri_o.req, 1);
    chk("rd_m2_wen", bus_if.dbus2peri_o.w_en, 0);
    chk("rd_m2_wdata", bus_if.dbus2peri_o.w_data, 0);
    tick();
    tick();
    chk("rd_rsp_valid", bus_if.rsp_valid_o, 1);
    chk("rd_rsp_rdata", bus_if.rsp_rdata_o, 32'hA5);
    chk("rd_rsp_we", bus_if.rsp_we_o, 0);
    chk("rd_rsp_err", bus_if.rsp_err_o, 0);
    tick();
    chk("rd_done_valid", bus_if.rsp_valid_o, 0);
    chk("rd_done_busy", busy, 0);

    // Queue full
    bus_if.rsp_ready_i = 1'b0;
    base = req_rises;
    for (int k = 0; k < 5; k++) push(q_addr[k], q_wd[k], q_we[k]);
    chk("full_cmd_ready", bus_if.cmd_ready_o, 0);
    repeat (3) tick();
    chk("full_one_req", req_rises - base, 1);
    chk("full_still_full", bus_if.cmd_ready_o, 0);
    chk("full_busy", busy, 1);
    bus_if.rsp_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("q%0d_valid", k));
      chk($sformatf("q%0d_rdata", k), bus_if.rsp_rdata_o, q_exp[k]);
      chk($sformatf("q%0d_we", k), bus_if.rsp_we_o, q_we[k]);
      chk($sformatf("q%0d_err", k), bus_if.rsp_err_o, 0);
      tick();
    end
    chk("q_done_busy", busy, 0);
    chk("ack_req_overlap", ack_req_cycles, 7);

    // Timeout: no responder
    resp_en = 1'b0;
    bus_if.rsp_ready_i = 1'b0;
    push(32'h8, 32'h0, 1'b0);
    tick();
`ifdef DBUS_INIT_TIMEOUT_EN
    begin
      int hi = 0;
      for (int i = 0; i < 16; i++) begin
        if (bus_if.dbus2peri_o.req) hi++;
        tick();
      end
      chk("to_req_cycles", hi, 16);
    end
    chk("to_req_low", bus_if.dbus2peri_o.req, 0);
    chk("to_rsp_valid", bus_if.rsp_valid_o, 1);
    chk("to_rsp_err", bus_if.rsp_err_o, 1);
    chk("to_rsp_rdata", bus_if.rsp_rdata_o, 0);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    chk("to_consumed", bus_if.rsp_valid_o, 0);
    push(32'h8, 32'h0, 1'b0);
    tick();
`else
    repeat (100) tick();
    chk("noto_req_high", bus_if.dbus2peri_o.req, 1);
    chk("noto_rsp_valid", bus_if.rsp_valid_o, 0);
`endif

    // Reset mid-REQ with a command still queued, then a late ack
    push(32'h0, 32'h1, 1'b1);
    chk("mid_req_high", bus_if.dbus2peri_o.req, 1);
    base = req_rises;
    rst = 1'b1;
    tick();
    chk("mid_rst_req", bus_if.dbus2peri_o.req, 0);
    chk("mid_rst_valid", bus_if.rsp_valid_o, 0);
    rst = 1'b0;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", bus_if.rsp_valid_o, 0);
    chk("post_rst_req", bus_if.dbus2peri_o.req, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", bus_if.cmd_ready_o, 1);
    chk("post_rst_no_req", req_rises - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
